// File: rtl/reaction_round_sequencer.sv
// reaction_round_sequencer
// Runs a multi-round reaction-time session. Each round arms a random
// pre-target delay, lights one target LED and times the matching switch in ms.
// Last, best and total response times are kept across ROUNDS trials.
//
// Optional build macro: FALSE_START_EN. When defined, any switch rising during
// DELAY ends the round as a miss (TIMEOUT_MS) with a fault pulse.
//
// Ports
//   ADC_CLK_10  system clock, posedge
//   reset       asynchronous active-high reset
//   ms_tick     1 ms strobe, one cycle wide
//   start       debounced start level; rising edge starts a session
//   rand_num    random source, sampled in ARM for the delay
//   target_sel  random target index, sampled in ARM (10..15 fold to 0..5)
//   sw          synchronised slide switches
//   led         one-hot target LED, 0 when no target is lit
//   busy        high in all states except IDLE/DONE
//   state_code  current state encoding
//   round_num   rounds completed this session
//   last_time   last recorded response, ms
//   best_time   minimum response this session, ms
//   total_time  saturating sum of responses this session, ms
//   done        one-cycle pulse when the final round is recorded
//   fault       one-cycle pulse on timeout (or false start)
module reaction_round_sequencer #(
  parameter int unsigned ROUNDS       = 5,
  parameter int unsigned MIN_DELAY_MS = 500,
  parameter logic [14:0] DELAY_MASK   = 15'h0FFF,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter int unsigned TW           = 14
) (
  input  logic            ADC_CLK_10,
  input  logic            reset,
  input  logic            ms_tick,
  input  logic            start,
  input  logic [14:0]     rand_num,
  input  logic [3:0]      target_sel,
  input  logic [9:0]      sw,
  output logic [9:0]      led,
  output logic            busy,
  output logic [2:0]      state_code,
  output logic [3:0]      round_num,
  output logic [TW-1:0]   last_time,
  output logic [TW-1:0]   best_time,
  output logic [TW+3:0]   total_time,
  output logic            done,
  output logic            fault
);

  localparam int unsigned DW   = 16;
  localparam int unsigned TOTW = TW + 4;
  localparam int unsigned TSW  = TOTW + 1;
  localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_MS);
  localparam logic [4:0]    ROUNDS_V  = 5'(ROUNDS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    DELAY   = 3'd2,
    WAIT_SW = 3'd3,
    RECORD  = 3'd4,
    GAP     = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t          state, state_d;
  logic            start_q;
  logic [9:0]      sw_q;
  logic [DW-1:0]   delay_cnt, delay_d;
  logic [TW-1:0]   resp_cnt, resp_d;
  logic [3:0]      target, target_d;
  logic [9:0]      led_d;
  logic            busy_d;
  logic [3:0]      round_d;
  logic [TW-1:0]   last_d, best_d;
  logic [TOTW-1:0] total_d;
  logic            done_d, fault_d;

  logic            start_rise_c;
  logic            false_start_c;
  logic [TW-1:0]   resp_next_c;
  logic [TSW-1:0]  total_sum_c;

  assign start_rise_c = start & ~start_q;

  // Any switch rising while waiting for the target counts as jumping the gun
`ifdef FALSE_START_EN
  assign false_start_c = |(sw & ~sw_q);
`else
  assign false_start_c = 1'b0;
`endif

  // Response counter advanced by this cycle's tick, saturating at the miss value
  assign resp_next_c = (ms_tick && (resp_cnt < TIMEOUT_V)) ? resp_cnt + TW'(1) : resp_cnt;

  // One extra bit catches overflow of the running total
  assign total_sum_c = {1'b0, total_time} + TSW'(resp_cnt);

  assign state_code = state;

  // Next-state and next-output logic
  always_comb begin
    state_d  = state;
    delay_d  = delay_cnt;
    resp_d   = resp_cnt;
    target_d = target;
    led_d    = led;
    round_d  = round_num;
    last_d   = last_time;
    best_d   = best_time;
    total_d  = total_time;
    done_d   = 1'b0;
    fault_d  = 1'b0;

    case (state)
      IDLE: begin
        if (start_rise_c) state_d = ARM;
      end
      ARM: begin
        delay_d  = DW'(MIN_DELAY_MS) + DW'(rand_num & DELAY_MASK);
        target_d = (target_sel >= 4'd10) ? target_sel - 4'd10 : target_sel;
        state_d  = DELAY;
      end
      DELAY: begin
        if (false_start_c) begin
          resp_d  = TIMEOUT_V;
          fault_d = 1'b1;
          state_d = RECORD;
        end else if (ms_tick) begin
          // <= 1 also covers a zero-length delay without wrapping
          if (delay_cnt <= DW'(1)) begin
            led_d   = 10'(1) << target;
            resp_d  = '0;
            state_d = WAIT_SW;
          end else begin
            delay_d = delay_cnt - DW'(1);
          end
        end
      end
      WAIT_SW: begin
        resp_d = resp_next_c;
        if (sw[target]) begin
          state_d = RECORD;
        end else if (resp_next_c == TIMEOUT_V) begin
          fault_d = 1'b1;
          state_d = RECORD;
        end
      end
      RECORD: begin
        last_d  = resp_cnt;
        if (resp_cnt < best_time) best_d = resp_cnt;
        total_d = total_sum_c[TOTW] ? '1 : total_sum_c[TOTW-1:0];
        round_d = round_num + 4'd1;
        led_d   = '0;
        if (({1'b0, round_num} + 5'd1) == ROUNDS_V) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        // Switches must be released for a whole cycle before the next tick re-arms
        if (ms_tick && (sw == '0) && (sw_q == '0)) state_d = ARM;
      end
      DONE: begin
        if (start_rise_c) begin
          round_d = '0;
          last_d  = '0;
          total_d = '0;
          best_d  = TIMEOUT_V;
          state_d = ARM;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) && (state_d != DONE);
  end

  // State and output registers
  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      sw_q       <= '0;
      delay_cnt  <= '0;
      resp_cnt   <= '0;
      target     <= '0;
      led        <= '0;
      busy       <= 1'b0;
      round_num  <= '0;
      last_time  <= '0;
      best_time  <= TIMEOUT_V;
      total_time <= '0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_d;
      start_q    <= start;
      sw_q       <= sw;
      delay_cnt  <= delay_d;
      resp_cnt   <= resp_d;
      target     <= target_d;
      led        <= led_d;
      busy       <= busy_d;
      round_num  <= round_d;
      last_time  <= last_d;
      best_time  <= best_d;
      total_time <= total_d;
      done       <= done_d;
      fault      <= fault_d;
    end
  end

endmodule

// File: tb/tb_reaction_round_sequencer.sv
// Bench for reaction_round_sequencer: table of rounds driven in a loop,
// records checked by a scoreboard monitor, plus hand-written corner sequences.
module tb_reaction_round_sequencer;

  localparam int unsigned TW      = 14;
  localparam int          TIMEOUT = 9999;
  localparam int          NROUNDS = 3;

  logic            ADC_CLK_10 = 1'b0;
  logic            reset;
  logic            ms_tick;
  logic            start;
  logic [14:0]     rand_num;
  logic [3:0]      target_sel;
  logic [9:0]      sw;
  logic [9:0]      led;
  logic            busy;
  logic [2:0]      state_code;
  logic [3:0]      round_num;
  logic [TW-1:0]   last_time;
  logic [TW-1:0]   best_time;
  logic [TW+3:0]   total_time;
  logic            done;
  logic            fault;

  reaction_round_sequencer #(
    .ROUNDS(NROUNDS),
    .MIN_DELAY_MS(2),
    .DELAY_MASK(15'h0003),
    .TIMEOUT_MS(TIMEOUT),
    .TW(TW)
  ) dut (
    .ADC_CLK_10(ADC_CLK_10),
    .reset(reset),
    .ms_tick(ms_tick),
    .start(start),
    .rand_num(rand_num),
    .target_sel(target_sel),
    .sw(sw),
    .led(led),
    .busy(busy),
    .state_code(state_code),
    .round_num(round_num),
    .last_time(last_time),
    .best_time(best_time),
    .total_time(total_time),
    .done(done),
    .fault(fault)
  );

  always #5 ADC_CLK_10 = ~ADC_CLK_10;

  typedef struct {
    logic [3:0]  sel;
    logic [14:0] rnd;
    int          resp;
    bit          hit;
    bit          tick_with_hit;
    int          decoy;
    logic [9:0]  exp_led;
    int          exp_rec;
  } round_t;

  typedef struct {
    string nm;
    int    last;
    int    best;
    int    total;
    int    rnum;
    bit    flt;
    bit    dn;
  } exp_t;

  round_t tbl[7];
  exp_t   sbq[$];

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int fault_cnt = 0;
  int exp_dones = 0;
  int exp_faults = 0;

  int m_best, m_total, m_round;

  function automatic void check(string nm, longint act, longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endfunction

  task automatic cyc();
    @(posedge ADC_CLK_10);
    #1;
  endtask

  task automatic tick();
    ms_tick = 1'b1;
    cyc();
    ms_tick = 1'b0;
  endtask

  task automatic push_exp(string nm, int rec, bit flt);
    exp_t e;
    m_best  = (rec < m_best) ? rec : m_best;
    m_total = m_total + rec;
    m_round = m_round + 1;
    e.nm = nm; e.last = rec; e.best = m_best; e.total = m_total;
    e.rnum = m_round; e.flt = flt; e.dn = (m_round == NROUNDS);
    if (flt) exp_faults++;
    if (e.dn) exp_dones++;
    sbq.push_back(e);
  endtask

  // Scoreboard: compare results when the DUT leaves RECORD
  logic [2:0] prev_state = 3'd0;
  bit         rec_fault  = 1'b0;
  always @(negedge ADC_CLK_10) begin
    exp_t e;
    if (reset) begin
      prev_state = 3'd0;
    end else begin
      if (done)  done_cnt++;
      if (fault) fault_cnt++;
      if (state_code == 3'd4) rec_fault = fault;
      if (prev_state == 3'd4 && state_code != 3'd4) begin
        if (sbq.size() == 0) begin
          check("sb_unexpected_record", 1, 0);
        end else begin
          e = sbq.pop_front();
          check({e.nm, "_last"},  last_time,  e.last);
          check({e.nm, "_best"},  best_time,  e.best);
          check({e.nm, "_total"}, total_time, e.total);
          check({e.nm, "_round"}, round_num,  e.rnum);
          check({e.nm, "_fault"}, rec_fault,  e.flt);
          check({e.nm, "_done"},  done,       e.dn);
          check({e.nm, "_next"},  state_code, e.dn ? 6 : 5);
        end
      end
      prev_state = state_code;
    end
  end

  task automatic run_round(input int idx, input bit use_start, input bit keep_start);
    round_t r;
    string  nm;
    int     d, nt;
    r  = tbl[idx];
    nm = $sformatf("r%0d", idx);
    target_sel = r.sel;
    rand_num   = r.rnd;
    if (use_start) begin
      m_best = TIMEOUT; m_total = 0; m_round = 0;
      start = 1'b1;
      cyc();
      start = keep_start;
      check({nm, "_arm"}, state_code, 1);
      check({nm, "_clr_round"}, round_num, 0);
      check({nm, "_clr_last"},  last_time, 0);
      check({nm, "_clr_total"}, total_time, 0);
      check({nm, "_clr_best"},  best_time, TIMEOUT);
    end else begin
      start = keep_start;
      tick();
      check({nm, "_arm"}, state_code, 1);
    end
    cyc();
    check({nm, "_delay"}, state_code, 2);
    check({nm, "_busy"}, busy, 1);
    d = 2 + int'(r.rnd & 15'h0003);
    for (int i = 0; i < d - 1; i++) tick();
    check({nm, "_delay_end"}, state_code, 2);
    tick();
    check({nm, "_wait"}, state_code, 3);
    check({nm, "_led"}, led, r.exp_led);
    nt = r.hit ? (r.tick_with_hit ? r.resp - 1 : r.resp) : r.resp - 1;
    for (int i = 0; i < nt; i++) begin
      tick();
      if (i == 0 && r.decoy >= 0) begin
        sw = 10'(1) << r.decoy;
        cyc();
        sw = '0;
        check({nm, "_decoy"}, state_code, 3);
      end
    end
    if (r.hit) begin
      push_exp(nm, r.exp_rec, 1'b0);
      sw = r.exp_led;
      ms_tick = r.tick_with_hit;
      cyc();
      ms_tick = 1'b0;
    end else begin
      check({nm, "_pre_timeout"}, state_code, 3);
      push_exp(nm, r.exp_rec, 1'b1);
      tick();
    end
    check({nm, "_record"}, state_code, 4);
    cyc();
    check({nm, "_led_off"}, led, 0);
    if (m_round < NROUNDS) begin
      if (r.hit) begin
        tick();
        tick();
        check({nm, "_gap_hold"}, state_code, 5);
      end
      sw = '0;
      cyc();
    end else begin
      sw = '0;
      repeat (2) cyc();
      check({nm, "_done_hold"}, state_code, 6);
      start = 1'b0;
      cyc();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //          sel    rnd        resp   hit twh decoy led       rec
    tbl[0] = '{4'd3,  15'h7FFC, 40,    1'b1, 1'b0, 9,  10'h008, 40};
    tbl[1] = '{4'd12, 15'h0001, 25,    1'b1, 1'b1, 9,  10'h004, 25};
    tbl[2] = '{4'd9,  15'h0003, 30,    1'b1, 1'b0, 0,  10'h200, 30};
    tbl[3] = '{4'd3,  15'h0000, 7,     1'b1, 1'b0, -1, 10'h008, 7};
    tbl[4] = '{4'd1,  15'h0002, 9999,  1'b0, 1'b0, 2,  10'h002, 9999};
    tbl[5] = '{4'd15, 15'h4001, 1,     1'b1, 1'b0, -1, 10'h020, 1};
    tbl[6] = '{4'd2,  15'h0000, 3,     1'b1, 1'b1, -1, 10'h004, 3};

    reset = 1'b1; start = 1'b0; ms_tick = 1'b0;
    rand_num = '0; target_sel = '0; sw = '0;
    m_best = TIMEOUT; m_total = 0; m_round = 0;
    repeat (2) cyc();
    check("rst_state", state_code, 0);
    check("rst_led", led, 0);
    check("rst_busy", busy, 0);
    check("rst_round", round_num, 0);
    check("rst_last", last_time, 0);
    check("rst_best", best_time, TIMEOUT);
    check("rst_total", total_time, 0);
    check("rst_done_fault", {done, fault}, 0);
    reset = 1'b0;
    cyc();
    tick();
    check("idle_no_start", state_code, 0);

    // Three sessions of rounds from the table
    for (int i = 0; i < 7; i++)
      run_round(i, (i == 0) || (i == 3) || (i == 6), (i == 5));
    check("sessions_done_cnt", done_cnt, exp_dones);

    // New round armed from GAP, then a switch rises during DELAY
    target_sel = 4'd4; rand_num = '0;
    tick();
    check("fs_arm", state_code, 1);
    cyc();
    tick();
    check("fs_delay", state_code, 2);
    sw = 10'h001;
`ifdef FALSE_START_EN
    push_exp("fs", TIMEOUT, 1'b1);
    cyc();
    check("fs_record", state_code, 4);
    cyc();
    check("fs_gap", state_code, 5);
    sw = '0;
    cyc();
    tick();
    cyc();
    check("fs_rearm_delay", state_code, 2);
`else
    cyc();
    check("fs_ignored", state_code, 2);
    check("fs_no_fault", fault, 0);
    check("fs_round", round_num, 1);
    sw = '0;
    cyc();
`endif

    // Asynchronous reset in the middle of DELAY
    @(posedge ADC_CLK_10);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_state", state_code, 0);
    check("mid_rst_led", led, 0);
    check("mid_rst_round", round_num, 0);
    check("mid_rst_best", best_time, TIMEOUT);
    check("mid_rst_total", total_time, 0);
    check("mid_rst_busy", busy, 0);
    cyc();
    reset = 1'b0;
    cyc();
    check("post_rst_idle", state_code, 0);

    check("sb_empty", sbq.size(), 0);
    check("done_pulses", done_cnt, exp_dones);
    check("fault_pulses", fault_cnt, exp_faults);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
